// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall/flush bundle between the pipeline and its stall controller.
//   master : pipeline side, drives stall causes and exception requests,
//            receives stall/flush vectors, PC redirect and counters.
//   slave  : controller side (pipeline_stall_ctrl).
// Vector bit map for stall/flush: [0] PC, [1] IF/ID, [2] ID/EXE,
// [3] EXE/MEM, [4] MEM/WB.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             stcl_lw;
    logic             stcl_jmp;
    logic             ibus_busy;
    logic             dbus_busy;
    logic             div_busy;
    logic             exc_req;
    logic [PC_W-1:0]  exc_pc;
    logic [4:0]       stall;
    logic [4:0]       flush;
    logic             pc_load;
    logic [PC_W-1:0]  flush_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] hazard_cnt;

    modport master (
        output stcl_lw, stcl_jmp, ibus_busy, dbus_busy, div_busy, exc_req, exc_pc,
        input  stall, flush, pc_load, flush_pc, stall_cnt, hazard_cnt
    );

    modport slave (
        input  stcl_lw, stcl_jmp, ibus_busy, dbus_busy, div_busy, exc_req, exc_pc,
        output stall, flush, pc_load, flush_pc, stall_cnt, hazard_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller. Merges ID hazard stalls, AXI bus and
// divider busy stalls and exception redirects into per-register stall and
// flush vectors plus a PC redirect. An exception raised while an AXI
// transfer is outstanding is parked (HOLD) until both buses are idle, then
// issued as a one-cycle flush (FLUSH).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipeline_stall_ctrl_if.slave (causes in, stall/flush,
//                pc_load/flush_pc and performance counters out)
// stall/flush/pc_load/flush_pc are combinational from state and inputs.
module pipeline_stall_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int unsigned NSTG = 5;

    localparam logic [NSTG-1:0] VEC_NONE   = 5'b00000;
    localparam logic [NSTG-1:0] VEC_ALL    = 5'b11111;
    localparam logic [NSTG-1:0] ST_MEM     = 5'b01111;
    localparam logic [NSTG-1:0] FL_MEM     = 5'b10000;
    localparam logic [NSTG-1:0] ST_EXE     = 5'b00111;
    localparam logic [NSTG-1:0] FL_EXE     = 5'b01000;
    localparam logic [NSTG-1:0] ST_ID      = 5'b00011;
    localparam logic [NSTG-1:0] FL_ID      = 5'b00100;
    localparam logic [NSTG-1:0] ST_IF      = 5'b00001;
    localparam logic [NSTG-1:0] FL_IF      = 5'b00010;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

    logic [NSTG-1:0]  stall_c;
    logic [NSTG-1:0]  flush_c;
    logic             pc_load_c;
    logic [PC_W-1:0]  flush_pc_c;
    logic             hazard_win_c;
    logic             bus_busy_c;

    // Cause arbitration, next state and zero-latency stall/flush outputs.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        stall_c      = VEC_NONE;
        flush_c      = VEC_NONE;
        pc_load_c    = 1'b0;
        flush_pc_c   = '0;
        hazard_win_c = 1'b0;
        bus_busy_c   = bus.ibus_busy | bus.dbus_busy;

        // Outputs are forced quiet while reset is held, whatever the inputs.
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.exc_req && !bus_busy_c) begin
                        flush_c    = VEC_ALL;
                        pc_load_c  = 1'b1;
                        flush_pc_c = bus.exc_pc;
                    end else if (bus.exc_req) begin
                        // Park the redirect until the AXI transfers drain.
                        stall_c = VEC_ALL;
                        tgt_d   = bus.exc_pc;
                        state_d = ST_HOLD;
                    end else if (bus.dbus_busy) begin
                        // ID/EXE holds too, so a coincident load-use stall loses nothing.
                        stall_c = ST_MEM;
                        flush_c = FL_MEM;
                    end else if (bus.div_busy) begin
                        stall_c = ST_EXE;
                        flush_c = FL_EXE;
                    end else if (bus.stcl_lw || bus.stcl_jmp) begin
                        // Already covers the PC hold an ibus stall would need.
                        stall_c      = ST_ID;
                        flush_c      = FL_ID;
                        hazard_win_c = 1'b1;
                    end else if (bus.ibus_busy) begin
                        stall_c = ST_IF;
                        flush_c = FL_IF;
                    end
                end

                ST_HOLD: begin
                    // Later exception requests and non-bus stalls are ignored here.
                    stall_c = VEC_ALL;
                    if (!bus_busy_c) begin
                        state_d = ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    flush_c    = VEC_ALL;
                    pc_load_c  = 1'b1;
                    flush_pc_c = tgt_q;
                    state_d    = ST_RUN;
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        if (stall_c[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hazard_win_c && (hazard_cnt_q != {CNT_W{1'b1}})) begin
            hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
        end
    end

    // State, latched redirect target and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            tgt_q        <= '0;
            stall_cnt_q  <= '0;
            hazard_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            stall_cnt_q  <= stall_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign bus.stall      = stall_c;
    assign bus.flush      = flush_c;
    assign bus.pc_load    = pc_load_c;
    assign bus.flush_pc   = flush_pc_c;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios with
// literal expectations, plus randomized traffic against a cause-table model.
// Counters are instantiated 8 bits wide so saturation is reached by traffic.
module tb_pipeline_stall_ctrl;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cause index 0..6 selects stall/flush from a table.
    logic [4:0] st_tab [0:6] = '{5'b00000, 5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
    logic [4:0] fl_tab [0:6] = '{5'b11111, 5'b00000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00000};

    bit          m_pend, m_redir;
    logic [31:0] m_tgt;
    int unsigned m_scnt, m_hcnt;
    bit          n_pend, n_redir;
    logic [31:0] n_tgt;
    logic [4:0]  e_stall, e_flush;
    logic        e_pcl, e_haz;
    logic [31:0] e_fpc;

    task automatic model_eval();
        int  cause;
        bit  busy;
        busy    = bus.ibus_busy | bus.dbus_busy;
        n_pend  = m_pend;
        n_redir = 1'b0;
        n_tgt   = m_tgt;
        e_pcl   = 1'b0;
        e_fpc   = 32'h0;
        e_haz   = 1'b0;
        if (m_redir) begin
            e_stall = 5'b00000;
            e_flush = 5'b11111;
            e_pcl   = 1'b1;
            e_fpc   = m_tgt;
        end else if (m_pend) begin
            e_stall = 5'b11111;
            e_flush = 5'b00000;
            if (!busy) begin
                n_pend  = 1'b0;
                n_redir = 1'b1;
            end
        end else begin
            if (bus.exc_req && !busy)                cause = 0;
            else if (bus.exc_req)                    cause = 1;
            else if (bus.dbus_busy)                  cause = 2;
            else if (bus.div_busy)                   cause = 3;
            else if (bus.stcl_lw || bus.stcl_jmp)    cause = 4;
            else if (bus.ibus_busy)                  cause = 5;
            else                                     cause = 6;
            e_stall = st_tab[cause];
            e_flush = fl_tab[cause];
            if (cause == 0) begin
                e_pcl = 1'b1;
                e_fpc = bus.exc_pc;
            end
            if (cause == 1) begin
                n_pend = 1'b1;
                n_tgt  = bus.exc_pc;
            end
            e_haz = (cause == 4);
        end
    endtask

    task automatic model_commit();
        if (e_stall[0] && m_scnt < CNT_MAX) m_scnt++;
        if (e_haz && m_hcnt < CNT_MAX) m_hcnt++;
        m_pend  = n_pend;
        m_redir = n_redir;
        m_tgt   = n_tgt;
    endtask

    task automatic set_in(input bit lw, input bit jmp, input bit ib, input bit db,
                          input bit dv, input bit exc, input logic [31:0] epc);
        bus.stcl_lw   = lw;
        bus.stcl_jmp  = jmp;
        bus.ibus_busy = ib;
        bus.dbus_busy = db;
        bus.div_busy  = dv;
        bus.exc_req   = exc;
        bus.exc_pc    = epc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_pend  = 0;
        m_redir = 0;
        m_tgt   = 32'h0;
        m_scnt  = 0;
        m_hcnt  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (5) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.stall !== 5'b0 || bus.flush !== 5'b0 || bus.pc_load !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle_vec: stall=%b flush=%b pc_load=%b, want 0/0/0", bus.stall, bus.flush, bus.pc_load);
            end
        end
        n_checks++;
        if (bus.stall_cnt !== 8'd0 || bus.hazard_cnt !== 8'd0 || bus.flush_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_idle_cnt: stall_cnt=%0d hazard_cnt=%0d flush_pc=%h, want 0/0/0", bus.stall_cnt, bus.hazard_cnt, bus.flush_pc);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        set_in(1, 0, 1, 0, 0, 0, 32'h0);
        #1;
        n_checks++;
        if (bus.stall !== 5'b00011 || bus.flush !== 5'b00100) begin
            n_errors++;
            $display("FAIL load_use_vec: stall=%b flush=%b, want 00011/00100", bus.stall, bus.flush);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        n_checks++;
        if (bus.stall_cnt !== 8'd1 || bus.hazard_cnt !== 8'd1 || bus.stall !== 5'b0) begin
            n_errors++;
            $display("FAIL load_use_cnt: stall_cnt=%0d hazard_cnt=%0d stall=%b, want 1/1/00000", bus.stall_cnt, bus.hazard_cnt, bus.stall);
        end
    endtask

    task automatic test_div_with_jmp();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_in(0, 1, 0, 0, 1, 0, 32'h0);
            #1;
            n_checks++;
            if (bus.stall !== 5'b00111 || bus.flush !== 5'b01000) begin
                n_errors++;
                $display("FAIL div_vec[%0d]: stall=%b flush=%b, want 00111/01000", i, bus.stall, bus.flush);
            end
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        n_checks++;
        if (bus.stall_cnt !== 8'd8 || bus.hazard_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL div_cnt: stall_cnt=%0d hazard_cnt=%0d, want 8/0", bus.stall_cnt, bus.hazard_cnt);
        end
    endtask

    task automatic test_exc_direct();
        do_reset();
        @(negedge clk);
        set_in(1, 0, 0, 0, 1, 1, 32'hBFC0_0380);
        #1;
        n_checks++;
        if (bus.flush !== 5'b11111 || bus.stall !== 5'b0 || bus.pc_load !== 1'b1 || bus.flush_pc !== 32'hBFC0_0380) begin
            n_errors++;
            $display("FAIL exc_direct: flush=%b stall=%b pc_load=%b flush_pc=%h, want 11111/00000/1/bfc00380",
                     bus.flush, bus.stall, bus.pc_load, bus.flush_pc);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        #1;
        n_checks++;
        if (bus.stall !== 5'b0 || bus.pc_load !== 1'b0 || bus.flush_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL exc_direct_after: stall=%b pc_load=%b flush_pc=%h, want 00000/0/0", bus.stall, bus.pc_load, bus.flush_pc);
        end
    endtask

    task automatic test_exc_deferred();
        logic [31:0] epc [0:3] = '{32'h8000_0180, 32'h0, 32'h0, 32'h0};
        bit          exc [0:3] = '{1, 0, 1, 1};
        bit          db  [0:3] = '{1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, db[i], 0, exc[i], epc[i]);
            #1;
            n_checks++;
            if (bus.stall !== 5'b11111 || bus.flush !== 5'b0 || bus.pc_load !== 1'b0 || bus.flush_pc !== 32'h0) begin
                n_errors++;
                $display("FAIL exc_hold[%0d]: stall=%b flush=%b pc_load=%b flush_pc=%h, want 11111/00000/0/0",
                         i, bus.stall, bus.flush, bus.pc_load, bus.flush_pc);
            end
        end
        // Request during the flush cycle must also be dropped.
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        #1;
        n_checks++;
        if (bus.pc_load !== 1'b1 || bus.flush_pc !== 32'h8000_0180 || bus.flush !== 5'b11111 || bus.stall !== 5'b0) begin
            n_errors++;
            $display("FAIL exc_flush: pc_load=%b flush_pc=%h flush=%b stall=%b, want 1/80000180/11111/00000",
                     bus.pc_load, bus.flush_pc, bus.flush, bus.stall);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 32'h0);
            #1;
            n_checks++;
            if (bus.pc_load !== 1'b0 || bus.stall !== 5'b0 || bus.flush !== 5'b0) begin
                n_errors++;
                $display("FAIL exc_dropped[%0d]: pc_load=%b stall=%b flush=%b, want 0/00000/00000", i, bus.pc_load, bus.stall, bus.flush);
            end
        end
        n_checks++;
        if (bus.stall_cnt !== 8'd4) begin
            n_errors++;
            $display("FAIL exc_stall_cnt: stall_cnt=%0d, want 4", bus.stall_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (300) begin
            @(negedge clk);
            set_in(0, 0, 0, 1, 0, 0, 32'h0);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        n_checks++;
        if (bus.stall_cnt !== 8'hFF || bus.hazard_cnt !== 8'h00) begin
            n_errors++;
            $display("FAIL sat_stall: stall_cnt=%0d hazard_cnt=%0d, want 255/0", bus.stall_cnt, bus.hazard_cnt);
        end
        repeat (300) begin
            @(negedge clk);
            set_in(1, 0, 0, 0, 0, 0, 32'h0);
        end
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        n_checks++;
        if (bus.stall_cnt !== 8'hFF || bus.hazard_cnt !== 8'hFF) begin
            n_errors++;
            $display("FAIL sat_hazard: stall_cnt=%0d hazard_cnt=%0d, want 255/255", bus.stall_cnt, bus.hazard_cnt);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        @(negedge clk);
        set_in(1, 0, 0, 1, 0, 0, 32'h0);
        @(negedge clk);
        set_in(0, 0, 0, 1, 0, 1, 32'hA000_0000);
        @(negedge clk);
        set_in(1, 1, 1, 1, 1, 1, 32'h5555_5555);
        #1;
        n_checks++;
        if (bus.stall !== 5'b11111) begin
            n_errors++;
            $display("FAIL mid_hold_enter: stall=%b, want 11111", bus.stall);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.stall !== 5'b0 || bus.flush !== 5'b0 || bus.pc_load !== 1'b0 || bus.flush_pc !== 32'h0 ||
            bus.stall_cnt !== 8'd0 || bus.hazard_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL async_reset: stall=%b flush=%b pc_load=%b flush_pc=%h stall_cnt=%0d hazard_cnt=%0d, want all 0",
                     bus.stall, bus.flush, bus.pc_load, bus.flush_pc, bus.stall_cnt, bus.hazard_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.pc_load !== 1'b0 || bus.stall !== 5'b0 || bus.flush !== 5'b0) begin
                n_errors++;
                $display("FAIL post_reset[%0d]: pc_load=%b stall=%b flush=%b, want 0/00000/00000", i, bus.pc_load, bus.stall, bus.flush);
            end
        end
    endtask

    task automatic test_random();
        bit db_hold;
        do_reset();
        db_hold = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            // Data bus busy tends to persist, giving multi-cycle HOLD episodes.
            db_hold = ($urandom_range(0, 3) == 0) ? ~db_hold : db_hold;
            set_in($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                   db_hold, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
            #1;
            model_eval();
            n_checks++;
            if (bus.stall !== e_stall) begin
                n_errors++;
                $display("FAIL rnd_stall[%0d]: got %b want %b", i, bus.stall, e_stall);
            end
            n_checks++;
            if (bus.flush !== e_flush) begin
                n_errors++;
                $display("FAIL rnd_flush[%0d]: got %b want %b", i, bus.flush, e_flush);
            end
            n_checks++;
            if (bus.pc_load !== e_pcl || bus.flush_pc !== e_fpc) begin
                n_errors++;
                $display("FAIL rnd_redirect[%0d]: pc_load=%b flush_pc=%h want %b/%h", i, bus.pc_load, bus.flush_pc, e_pcl, e_fpc);
            end
            n_checks++;
            if (bus.stall_cnt !== CNT_W'(m_scnt) || bus.hazard_cnt !== CNT_W'(m_hcnt)) begin
                n_errors++;
                $display("FAIL rnd_cnt[%0d]: stall_cnt=%0d hazard_cnt=%0d want %0d/%0d", i, bus.stall_cnt, bus.hazard_cnt, m_scnt, m_hcnt);
            end
            model_commit();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 32'h0);
        test_reset();
        test_load_use();
        test_div_with_jmp();
        test_exc_direct();
        test_exc_deferred();
        test_random();
        test_saturation();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
